// File: rtl/rdata_handler_if.sv
// rtl/rdata_handler_if.sv - control, memory-read and array-feed bundle of the read-data handler
// Slave side is the handler; master side is whoever drives start and the memories.
interface rdata_handler_if #(
   parameter int SYS_ARRAY_SIZE = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 32
);
   localparam int ROW_BITS = SYS_ARRAY_SIZE * DATA_WIDTH;

   logic                                           start_i;
   logic [ADDR_WIDTH-1:0]                          addr_a_i;
   logic [ADDR_WIDTH-1:0]                          addr_b_i;
   logic [ADDR_WIDTH-1:0]                          addr_c_i;
   logic                                           busy_o;
   logic                                           done_o;
   logic                                           en_a_o;
   logic                                           en_b_o;
   logic [ADDR_WIDTH-1:0]                          addr_a_o;
   logic [ADDR_WIDTH-1:0]                          addr_b_o;
   logic [ROW_BITS-1:0]                            rdata_a_i;
   logic [ROW_BITS-1:0]                            rdata_b_i;
   logic                                           clear_o;
   logic [SYS_ARRAY_SIZE-1:0][DATA_WIDTH-1:0]      a_o;
   logic [SYS_ARRAY_SIZE-1:0][DATA_WIDTH-1:0]      b_o;
   logic                                           valid_o;
   logic [ADDR_WIDTH-1:0]                          addr_c_o;

   modport slave (
      input  start_i, addr_a_i, addr_b_i, addr_c_i, rdata_a_i, rdata_b_i,
      output busy_o, done_o, en_a_o, en_b_o, addr_a_o, addr_b_o,
             clear_o, a_o, b_o, valid_o, addr_c_o
   );

   modport master (
      output start_i, addr_a_i, addr_b_i, addr_c_i, rdata_a_i, rdata_b_i,
      input  busy_o, done_o, en_a_o, en_b_o, addr_a_o, addr_b_o,
             clear_o, a_o, b_o, valid_o, addr_c_o
   );
endinterface

// File: rtl/rdata_handler.sv
// rtl/rdata_handler.sv - fetches N rows of A and B, skews them into the array, then hands C off
// Sequencing is IDLE -> FETCH(N) -> DRAIN(N+DRAIN_CYCLES) -> WRITE(N) -> IDLE.
module rdata_handler #(
   parameter int SYS_ARRAY_SIZE = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 32,
   parameter int DRAIN_CYCLES   = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   rdata_handler_if.slave bus
);
   localparam int N         = SYS_ARRAY_SIZE;
   localparam int ROW_BITS  = N * DATA_WIDTH;
   localparam int ROW_BYTES = ROW_BITS / 8;
   localparam int CNT_W     = $clog2(N + DRAIN_CYCLES + 1);

   localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(N + DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
   logic [ADDR_WIDTH-1:0] b_base_q, b_base_d;
   logic [ADDR_WIDTH-1:0] c_base_q, c_base_d;
   logic                  rvalid_q;

   logic                  fetch;
   logic [ADDR_WIDTH-1:0] row_off;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_base_q <= '0;
         b_base_q <= '0;
         c_base_q <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_base_q <= a_base_d;
         b_base_q <= b_base_d;
         c_base_q <= c_base_d;
         rvalid_q <= (state_q == FETCH);
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_base_d = a_base_q;
      b_base_d = b_base_q;
      c_base_d = c_base_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d  = FETCH;
               cnt_d    = '0;
               a_base_d = bus.addr_a_i;
               b_base_d = bus.addr_b_i;
               c_base_d = bus.addr_c_i;
            end
         end
         FETCH: begin
            if (cnt_q == LAST_ROW) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == LAST_DRAIN) begin
               state_d = WRITE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WRITE: begin
            if (cnt_q == LAST_ROW) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fetch   = (state_q == FETCH);
   assign row_off = ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(ROW_BYTES);

   assign bus.busy_o   = (state_q != IDLE);
   assign bus.en_a_o   = fetch;
   assign bus.en_b_o   = fetch;
   assign bus.addr_a_o = fetch ? a_base_q + row_off : '0;
   assign bus.addr_b_o = fetch ? b_base_q + row_off : '0;
   assign bus.clear_o  = fetch && (cnt_q == '0);
   assign bus.valid_o  = (state_q == WRITE) && (cnt_q == '0);
   assign bus.done_o   = (state_q == WRITE) && (cnt_q == LAST_ROW);
   assign bus.addr_c_o = c_base_q;

   // Read data is zeroed outside its valid cycle so idle lanes shift zeros through the skew.
   logic [DATA_WIDTH-1:0] a_in   [N];
   logic [DATA_WIDTH-1:0] b_in   [N];
   logic [DATA_WIDTH-1:0] a_lane [N];
   logic [DATA_WIDTH-1:0] b_lane [N];

   for (genvar j = 0; j < N; j++) begin : g_lane
      assign a_in[j] = rvalid_q ? bus.rdata_a_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign b_in[j] = rvalid_q ? bus.rdata_b_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (j == 0) begin : g_direct
         assign a_lane[j] = a_in[j];
         assign b_lane[j] = b_in[j];
      end else begin : g_skew
         logic [DATA_WIDTH-1:0] a_pipe_q [j];
         logic [DATA_WIDTH-1:0] b_pipe_q [j];
         always_ff @(posedge clk_i) begin
            if (!rst_i) begin
               for (int s = 0; s < j; s++) begin
                  a_pipe_q[s] <= '0;
                  b_pipe_q[s] <= '0;
               end
            end else begin
               a_pipe_q[0] <= a_in[j];
               b_pipe_q[0] <= b_in[j];
               for (int s = 1; s < j; s++) begin
                  a_pipe_q[s] <= a_pipe_q[s-1];
                  b_pipe_q[s] <= b_pipe_q[s-1];
               end
            end
         end
         assign a_lane[j] = a_pipe_q[j-1];
         assign b_lane[j] = b_pipe_q[j-1];
      end
   end

   logic [N-1:0][DATA_WIDTH-1:0] a_pk, b_pk;

   always_comb begin
      a_pk = '0;
      b_pk = '0;
      for (int j = 0; j < N; j++) begin
         a_pk[j] = a_lane[j];
         b_pk[j] = b_lane[j];
      end
   end

   assign bus.a_o = a_pk;
   assign bus.b_o = b_pk;
endmodule

// File: tb/tb_rdata_handler.sv
// tb/tb_rdata_handler.sv - directed bench for rdata_handler with N=4, 8-bit lanes, DRAIN_CYCLES=4
// Cycle c is the interval after the c-th rising edge counted from the first accept.
module tb_rdata_handler;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 32;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   rdata_handler_if #(.SYS_ARRAY_SIZE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   rdata_handler #(
      .SYS_ARRAY_SIZE(N),
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .DRAIN_CYCLES  (DC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".busy"},  64'(bus.busy_o),   64'd0);
      chk({tag, ".done"},  64'(bus.done_o),   64'd0);
      chk({tag, ".valid"}, 64'(bus.valid_o),  64'd0);
      chk({tag, ".clear"}, 64'(bus.clear_o),  64'd0);
      chk({tag, ".en"},    64'({bus.en_a_o, bus.en_b_o}), 64'd0);
      chk({tag, ".addra"}, 64'(bus.addr_a_o), 64'd0);
      chk({tag, ".addrb"}, 64'(bus.addr_b_o), 64'd0);
      chk({tag, ".addrc"}, 64'(bus.addr_c_o), 64'd0);
      chk({tag, ".a"},     64'(bus.a_o),      64'd0);
      chk({tag, ".b"},     64'(bus.b_o),      64'd0);
   endtask

   // Expected outputs rel cycles after an accept; with data set, A row 0 = 04030201
   // arrives at rel 2 and B row 1 = 0D0C0B0A at rel 3.
   task automatic chk_rel(input int rel, input logic [31:0] ab, input logic [31:0] bb,
                          input logic [31:0] cb, input bit data);
      logic        en;
      logic [31:0] ea, eb, xa, xb;
      en = (rel >= 1) && (rel <= N);
      ea = en ? ab + 32'((rel - 1) * 4) : 32'd0;
      eb = en ? bb + 32'((rel - 1) * 4) : 32'd0;
      xa = '0;
      xb = '0;
      if (data) begin
         for (int j = 0; j < N; j++) begin
            if (rel == 2 + j) xa[j*8 +: 8] = 8'(j + 1);
            if (rel == 3 + j) xb[j*8 +: 8] = 8'(8'h0A + j);
         end
      end
      chk($sformatf("busy@%0d", rel),  64'(bus.busy_o),   64'd1);
      chk($sformatf("en_a@%0d", rel),  64'(bus.en_a_o),   64'(en));
      chk($sformatf("en_b@%0d", rel),  64'(bus.en_b_o),   64'(en));
      chk($sformatf("addra@%0d", rel), 64'(bus.addr_a_o), 64'(ea));
      chk($sformatf("addrb@%0d", rel), 64'(bus.addr_b_o), 64'(eb));
      chk($sformatf("clear@%0d", rel), 64'(bus.clear_o),  64'(rel == 1));
      chk($sformatf("valid@%0d", rel), 64'(bus.valid_o),  64'(rel == 13));
      chk($sformatf("done@%0d", rel),  64'(bus.done_o),   64'(rel == 16));
      chk($sformatf("addrc@%0d", rel), 64'(bus.addr_c_o), 64'(cb));
      chk($sformatf("a_o@%0d", rel),   64'(bus.a_o),      64'(xa));
      chk($sformatf("b_o@%0d", rel),   64'(bus.b_o),      64'(xb));
   endtask

   initial begin
      rst           = 1'b0;
      bus.start_i   = 1'b0;
      bus.addr_a_i  = '0;
      bus.addr_b_i  = '0;
      bus.addr_c_i  = '0;
      bus.rdata_a_i = '0;
      bus.rdata_b_i = '0;
      tick();
      tick();
      chk_zero("reset");

      // Op 1: nominal timing, skew data, and an ignored start at cycle 6.
      rst          = 1'b1;
      bus.start_i  = 1'b1;
      bus.addr_a_i = 32'h100;
      bus.addr_b_i = 32'h200;
      bus.addr_c_i = 32'h300;
      #1;
      chk("busy@0", 64'(bus.busy_o), 64'd0);
      for (int c = 1; c <= 16; c++) begin
         tick();
         bus.start_i = (c == 6);
         if (c == 6) begin
            bus.addr_a_i = 32'h500;
            bus.addr_b_i = 32'h600;
            bus.addr_c_i = 32'h700;
         end
         bus.rdata_a_i = (c == 2) ? 32'h04030201 : 32'h0;
         bus.rdata_b_i = (c == 3) ? 32'h0D0C0B0A : 32'h0;
         #1;
         chk_rel(c, 32'h100, 32'h200, 32'h300, 1'b1);
      end

      // Op 2: back-to-back accept at cycle 17 with a wrapping A base.
      tick();
      bus.start_i  = 1'b1;
      bus.addr_a_i = 32'hFFFF_FFFC;
      bus.addr_b_i = 32'h10;
      bus.addr_c_i = 32'h400;
      #1;
      chk("busy@17", 64'(bus.busy_o), 64'd0);
      chk("done@17", 64'(bus.done_o), 64'd0);
      for (int r = 1; r <= 16; r++) begin
         tick();
         bus.start_i = 1'b0;
         #1;
         chk_rel(r, 32'hFFFF_FFFC, 32'h10, 32'h400, 1'b0);
      end

      // Op 3: reset at rel 6 together with a start that must be ignored.
      tick();
      chk("busy@34", 64'(bus.busy_o), 64'd0);
      bus.start_i  = 1'b1;
      bus.addr_a_i = 32'h1000;
      bus.addr_b_i = 32'h2000;
      bus.addr_c_i = 32'h3000;
      for (int r = 1; r <= 6; r++) begin
         tick();
         bus.start_i = 1'b0;
         #1;
         chk_rel(r, 32'h1000, 32'h2000, 32'h3000, 1'b0);
      end
      rst         = 1'b0;
      bus.start_i = 1'b1;
      tick();
      rst         = 1'b1;
      bus.start_i = 1'b0;
      #1;
      chk_zero("midrst");
      for (int r = 0; r < 16; r++) begin
         tick();
         chk_zero($sformatf("post%0d", r));
      end

      // Op 4: fresh operation after reset keeps nominal timing.
      bus.start_i  = 1'b1;
      bus.addr_a_i = 32'h2000;
      bus.addr_b_i = 32'h3000;
      bus.addr_c_i = 32'h4000;
      for (int r = 1; r <= 16; r++) begin
         tick();
         bus.start_i = 1'b0;
         #1;
         chk_rel(r, 32'h2000, 32'h3000, 32'h4000, 1'b0);
      end
      tick();
      chk("busy_end", 64'(bus.busy_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
